// File: rtl/pipe_skid_reg.sv
// Two-entry elastic pipeline register (main + skid) with registered in_ready/out_valid.
// Optional stall/drop counters are built when PIPE_SKID_STATS_EN is defined.
module pipe_skid_reg #(
  parameter int unsigned CTRL_W            = 9,
  parameter int unsigned DATA_W            = 32,
  parameter bit          CLR_DATA_ON_FLUSH = 1'b1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [CTRL_W-1:0] in_ctrl,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [DATA_W-1:0] out_data,
  output logic [1:0]        occupancy,
  output logic [1:0]        dbg_state
`ifdef PIPE_SKID_STATS_EN
  ,
  output logic [15:0]       stall_cnt,
  output logic [7:0]        drop_cnt
`endif
);

  // Handshake: a beat moves on a rising edge where valid and ready are both 1;
  // valid never depends on ready, and a stalled beat must hold its payload.
  typedef enum logic [1:0] {
    ST_EMPTY   = 2'b00,
    ST_ONE     = 2'b01,
    ST_ILLEGAL = 2'b10,
    ST_FULL    = 2'b11
  } state_e;

  logic              main_valid_q, main_valid_d;
  logic [CTRL_W-1:0] main_ctrl_q,  main_ctrl_d;
  logic [DATA_W-1:0] main_data_q,  main_data_d;
  logic              skid_valid_q, skid_valid_d;
  logic [CTRL_W-1:0] skid_ctrl_q,  skid_ctrl_d;
  logic [DATA_W-1:0] skid_data_q,  skid_data_d;
  state_e            state;
  logic              acc;
  logic              pop;

  assign state     = state_e'({skid_valid_q, main_valid_q});
  assign dbg_state = state;
  assign in_ready  = ~skid_valid_q;
  assign out_valid = main_valid_q;
  assign out_ctrl  = main_valid_q ? main_ctrl_q : '0;
  assign out_data  = main_data_q;
  assign occupancy = {1'b0, main_valid_q} + {1'b0, skid_valid_q};
  assign acc       = in_valid & in_ready;
  assign pop       = main_valid_q & out_ready;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      main_valid_q <= 1'b0;
      main_ctrl_q  <= '0;
      main_data_q  <= '0;
      skid_valid_q <= 1'b0;
      skid_ctrl_q  <= '0;
      skid_data_q  <= '0;
    end else begin
      main_valid_q <= main_valid_d;
      main_ctrl_q  <= main_ctrl_d;
      main_data_q  <= main_data_d;
      skid_valid_q <= skid_valid_d;
      skid_ctrl_q  <= skid_ctrl_d;
      skid_data_q  <= skid_data_d;
    end
  end

  always_comb begin
    main_valid_d = main_valid_q;
    main_ctrl_d  = main_ctrl_q;
    main_data_d  = main_data_q;
    skid_valid_d = skid_valid_q;
    skid_ctrl_d  = skid_ctrl_q;
    skid_data_d  = skid_data_q;
    if (flush) begin
      main_valid_d = 1'b0;
      main_ctrl_d  = '0;
      skid_valid_d = 1'b0;
      skid_ctrl_d  = '0;
      if (CLR_DATA_ON_FLUSH) begin
        main_data_d = '0;
        skid_data_d = '0;
      end
    end else begin
      unique case (state)
        ST_EMPTY: begin
          if (acc) begin
            main_valid_d = 1'b1;
            main_ctrl_d  = in_ctrl;
            main_data_d  = in_data;
          end
        end
        ST_ONE: begin
          if (acc && pop) begin
            main_ctrl_d = in_ctrl;
            main_data_d = in_data;
          end else if (acc) begin
            skid_valid_d = 1'b1;
            skid_ctrl_d  = in_ctrl;
            skid_data_d  = in_data;
          end else if (pop) begin
            main_valid_d = 1'b0;
          end
        end
        ST_FULL: begin
          // in_ready is low here, so only the downstream side can move.
          if (pop) begin
            main_ctrl_d  = skid_ctrl_q;
            main_data_d  = skid_data_q;
            skid_valid_d = 1'b0;
          end
        end
        default: begin
          main_valid_d = 1'b0;
          skid_valid_d = 1'b0;
        end
      endcase
    end
  end

`ifdef PIPE_SKID_STATS_EN
  logic [15:0] stall_cnt_q;
  logic [7:0]  drop_cnt_q;
  logic [8:0]  drop_sum;

  assign drop_sum  = {1'b0, drop_cnt_q} + {7'b0, occupancy};
  assign stall_cnt = stall_cnt_q;
  assign drop_cnt  = drop_cnt_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stall_cnt_q <= '0;
      drop_cnt_q  <= '0;
    end else begin
      if (main_valid_q && !out_ready && stall_cnt_q != 16'hFFFF)
        stall_cnt_q <= stall_cnt_q + 16'd1;
      if (flush)
        drop_cnt_q <= drop_sum[8] ? 8'hFF : drop_sum[7:0];
    end
  end
`endif

`ifndef SYNTHESIS
  a_hold_stalled_beat: assert property (@(posedge clk) disable iff (reset)
    (in_valid && !in_ready) |=> (!in_valid || ($stable(in_ctrl) && $stable(in_data))))
    else $error("pipe_skid_reg: upstream changed a stalled beat");
  a_no_illegal_state: assert property (@(posedge clk) disable iff (reset)
    !(skid_valid_q && !main_valid_q))
    else $error("pipe_skid_reg: skid held without main entry");
`endif

endmodule

// File: doc/pipe_skid_reg.md
Name: pipe_skid_reg

Overview:
- Parametrised successor to the fixed-width stall/flush pipeline registers.
- Generic two-entry elastic stage: ctrl and data buses of any width, valid/ready handshake in place of a global stall, internal skid entry so upstream ready is a register output.
- Drop-in between any two CPU stages (IF/ID, ID/EX, EX/MEM, MEM/WB); cuts the combinational stall path through the pipeline.

Parameters:
- CTRL_W, 9, width of the control bundle; zeroed on flush/reset.
- DATA_W, 32, width of the data bundle.
- CLR_DATA_ON_FLUSH, 1, 1 = data entries zeroed on flush; 0 = data retained, only valid/ctrl cleared.

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- flush  in  1  synchronous discard of all held entries.
- in_valid  in  1  upstream beat present.
- in_ready  out  1  stage can accept; registered, equals !skid_valid.
- in_ctrl  in  CTRL_W  upstream control bundle.
- in_data  in  DATA_W  upstream data bundle.
- out_valid  out  1  main entry valid.
- out_ready  in  1  downstream accepts.
- out_ctrl  out  CTRL_W  main entry ctrl; forced to 0 when out_valid=0.
- out_data  out  DATA_W  main entry data.
- occupancy  out  2  number of held entries, 0..2.

Behaviour:
- Storage: main {valid,ctrl,data} drives the outputs; skid {valid,ctrl,data} holds overflow.
- States, encoded by {skid_valid, main_valid}: EMPTY=00, ONE=01, FULL=11. State 10 is illegal and unreachable.
- Definitions: acc = in_valid & in_ready; pop = out_valid & out_ready.
- EMPTY: acc loads main; goes to ONE.
- ONE:
  - acc & pop: main <= input; stays ONE.
  - acc & !pop: skid <= input; goes to FULL.
  - !acc & pop: goes to EMPTY.
  - otherwise holds.
- FULL: in_ready=0, so no acc. pop moves main <= skid, clears skid, goes to ONE.
- Latency: 1 cycle input to output when empty. Throughput: 1 beat/cycle with out_ready held high.
- Ordering is strict FIFO; no beat is duplicated or lost except on flush.
- flush=1:
  - Next state EMPTY; both valids and both ctrl fields cleared.
  - Data fields cleared only when CLR_DATA_ON_FLUSH=1.
  - An input beat in the same cycle is dropped, even though in_ready was 1.
  - Flush has priority over acc and pop.
- reset=1 (asynchronous, any time, including mid-transfer): all registers 0 immediately.
  - Outputs during reset: in_ready=1, out_valid=0, out_ctrl=0, out_data=0, occupancy=0.
- in_ready and out_valid are pure register outputs; there is no combinational in->out path on valid/ready.
- occupancy = main_valid + skid_valid.
- Upstream must hold in_ctrl/in_data stable while in_valid=1 and in_ready=0. A sim-only assertion flags violations.

Optional Feature:
- Macro: PIPE_SKID_STATS_EN.
- Defined:
  - Adds output stall_cnt [15:0]: increments each cycle with out_valid=1 & out_ready=0, saturates at 16'hFFFF.
  - Adds output drop_cnt [7:0]: increments by the number of valid entries discarded by flush (0..2), saturates at 8'hFF.
  - Both counters clear on reset only.
- Not defined: neither port nor counter exists; all other behaviour is identical.

Test Plan:
- Reset mid-stream: load A=0x11 (occupancy=1), assert reset asynchronously between edges -> out_valid=0, occupancy=0 and in_ready=1 without waiting for a clock edge.
- Streaming: out_ready=1, feed 0x1..0x8 back-to-back -> outputs 0x1..0x8 one cycle later, 1 beat/cycle, in_ready never drops.
- Backpressure: out_ready=0, send A=0xA, B=0xB -> occupancy=2, in_ready=0; raise out_ready -> A then B on consecutive cycles, in_ready=1 one cycle after A pops.
- Flush while FULL, with a new in_valid beat C in the same cycle -> next cycle occupancy=0, out_ctrl=0; C never appears. With CLR_DATA_ON_FLUSH=0, main data still reads 0xA.
- Random valid/ready toggling, 10k beats, against a scoreboard FIFO -> no loss, duplication or reorder; occupancy never 3; state 10 never reached.
- PIPE_SKID_STATS_EN: hold out_ready=0 with main valid for 70000 cycles -> stall_cnt=16'hFFFF. Flush while FULL -> drop_cnt +=2.
